fsm: RTL and testbench

- Serial divisibility detector. One bit per clock, MSB first.
- After each clock, flags whether the number received so far is an exact multiple of DIVISOR (default 3).
- Implemented as a Moore remainder-tracking state machine.
- Used as a leaf block for bit-serial checking of streamed values.

---
 rtl/fsm.sv | 71 +++++++
 tb/tb_fsm.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fsm.sv
// Bit-serial divisibility detector (MSB first): out is 1 while the prefix received so far is a multiple of DIVISOR.
// Optional macro FSM_REM_OUT_EN adds the rem_out and nonzero_seen ports.
module fsm #(
   parameter int DIVISOR = 3,
   localparam int REM_W = (DIVISOR > 2) ? $clog2(DIVISOR) : 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inbit,
   output logic             out
`ifdef FSM_REM_OUT_EN
   ,
   output logic [REM_W-1:0] rem_out,
   output logic             nonzero_seen
`endif
);

   // Each state value is the remainder itself; only the divisible state needs a name.
   typedef enum logic [REM_W-1:0] {S0 = {REM_W{1'b0}}} state_t;

   localparam logic [REM_W:0] DIV_EXT = (REM_W + 1)'(DIVISOR);

   state_t         rem_r;
   state_t         rem_next_s;
   logic [REM_W:0] sum_s;
   logic [REM_W:0] diff_s;

   // Remainder state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rem_r <= S0;
      end else begin
         rem_r <= rem_next_s;
      end
   end

   // 2*rem + inbit is below 2*DIVISOR, so one conditional subtract gives the new remainder
   always_comb begin
      sum_s      = {rem_r, inbit};
      diff_s     = sum_s - DIV_EXT;
      rem_next_s = S0;
      if ({1'b0, rem_r} >= DIV_EXT) begin
         rem_next_s = S0;
      end else if (sum_s >= DIV_EXT) begin
         rem_next_s = state_t'(diff_s[REM_W-1:0]);
      end else begin
         rem_next_s = state_t'(sum_s[REM_W-1:0]);
      end
   end

   assign out = (rem_r == S0);

`ifdef FSM_REM_OUT_EN
   logic nonzero_seen_r;

   // Sticky flag: set by the first 1 bit of the current number
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         nonzero_seen_r <= 1'b0;
      end else if (inbit) begin
         nonzero_seen_r <= 1'b1;
      end else begin
         nonzero_seen_r <= nonzero_seen_r;
      end
   end

   assign rem_out      = rem_r;
   assign nonzero_seen = nonzero_seen_r;
`endif

endmodule

// File: tb/tb_fsm.sv
// Self-checking bench for fsm: divisors 3, 5 and 2 share one serial input, checked every cycle
// against a value-mod-divisor model plus hand-computed literal sequences.
module tb_fsm;

   logic clock;
   logic reset;
   logic inbit;
   logic clk_en;
   logic out3, out5, out2;
`ifdef FSM_REM_OUT_EN
   logic [1:0] rem3;
   logic [2:0] rem5;
   logic [0:0] rem2;
   logic       nz3, nz5, nz2;
`endif

   int checks   = 0;
   int failures = 0;
   bit q[$];

   fsm #(.DIVISOR(3)) u3 (
      .clock(clock), .reset(reset), .inbit(inbit), .out(out3)
`ifdef FSM_REM_OUT_EN
      , .rem_out(rem3), .nonzero_seen(nz3)
`endif
   );

   fsm #(.DIVISOR(5)) u5 (
      .clock(clock), .reset(reset), .inbit(inbit), .out(out5)
`ifdef FSM_REM_OUT_EN
      , .rem_out(rem5), .nonzero_seen(nz5)
`endif
   );

   fsm #(.DIVISOR(2)) u2 (
      .clock(clock), .reset(reset), .inbit(inbit), .out(out2)
`ifdef FSM_REM_OUT_EN
      , .rem_out(rem2), .nonzero_seen(nz2)
`endif
   );

   // Gated clock so reset can be observed with no clock activity
   always #5 if (clk_en) clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Value of the received prefix modulo d
   function automatic int mod_of(input int d);
      int r;
      r = 0;
      foreach (q[i]) r = (r * 2 + int'(q[i])) % d;
      return r;
   endfunction

   function automatic int any_one();
      foreach (q[i]) if (q[i]) return 1;
      return 0;
   endfunction

   // Model: record each bit sampled while out of reset; reset discards the prefix
   always @(posedge clock) if (reset) q.push_back(inbit);
   always @(negedge reset) q.delete();

   // Per-cycle comparison against the model
   always @(negedge clock) begin
      chk("model_out_d3", out3, int'(mod_of(3) == 0));
      chk("model_out_d5", out5, int'(mod_of(5) == 0));
      chk("model_out_d2", out2, int'(mod_of(2) == 0));
`ifdef FSM_REM_OUT_EN
      chk("model_rem_d3", rem3, mod_of(3));
      chk("model_rem_d5", rem5, mod_of(5));
      chk("model_rem_d2", rem2, mod_of(2));
      chk("model_nz_d3", nz3, any_one());
      chk("model_nz_d5", nz5, any_one());
      chk("model_nz_d2", nz2, any_one());
`endif
   end

   task automatic send(input logic b);
      inbit = b;
      @(posedge clock);
      #1;
   endtask

   // Reset pulse placed between edges; out must rise without a clock
   task automatic do_reset();
      reset = 1'b0;
      #1;
      chk("reset_async_out", out3, 1);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      logic [15:0] pat16;
      logic [15:0] exp16;
      logic [3:0]  pat4;
      logic [3:0]  exp4;

      clock  = 1'b0;
      clk_en = 1'b0;
      reset  = 1'b0;
      inbit  = 1'b0;

      #3;
      chk("reset_idle_d3", out3, 1);
      chk("reset_idle_d5", out5, 1);
      chk("reset_idle_d2", out2, 1);
`ifdef FSM_REM_OUT_EN
      chk("reset_idle_rem", rem3, 0);
      chk("reset_idle_nz", nz3, 0);
`endif

      clk_en = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b1;
      chk("reset_release", out3, 1);

      pat16 = 16'h5772;
      exp16 = 16'b1000010110100011;
      for (int i = 15; i >= 0; i--) begin
         send(pat16[i]);
         chk("stream_5772", out3, int'(exp16[i]));
      end

      do_reset();
      pat4 = 4'b1010;
      for (int i = 3; i >= 0; i--) begin
         send(pat4[i]);
         chk("stream_1010", out3, 0);
      end
`ifdef FSM_REM_OUT_EN
      chk("rem_1010", rem3, 1);
      chk("nz_1010", nz3, 1);
`endif

      do_reset();
      send(1'b1);
      send(1'b0);
      chk("mid_s2", out3, 0);
      do_reset();
      send(1'b1);
      chk("mid_after_1", out3, 0);
      send(1'b1);
      chk("mid_after_11", out3, 1);

      do_reset();
      pat4 = 4'b1111;
      exp4 = 4'b0001;
      for (int i = 3; i >= 0; i--) begin
         send(pat4[i]);
         chk("d5_1111", out5, int'(exp4[i]));
      end

      do_reset();
      pat4 = 4'b0110;
      exp4 = 4'b0001;
      for (int i = 2; i >= 0; i--) begin
         send(pat4[i]);
         chk("d2_110", out2, int'(exp4[i]));
      end

      do_reset();
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         send(1'($urandom_range(0, 1)));
      end

      send(1'b0);
      send(1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
